// File: rtl/kalman_pkg.sv
// kalman_pkg: widths, FSM encoding, element indexing and saturation shared by the EKF stages.
package kalman_pkg;
  localparam int N = 32;
  localparam int Q = 18;
  localparam int ACC_W = 2 * N + 2;
  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

  function automatic logic signed [N-1:0] sat(input logic signed [ACC_W-1:0] v);
    return v > ACC_W'(SAT_MAX) ? SAT_MAX : v < ACC_W'(SAT_MIN) ? SAT_MIN : v[N-1:0];
  endfunction
endpackage

// File: rtl/kalman_mac.sv
// kalman_mac: single-cycle signed MAC; clr restarts the sum, res_o is the shifted and saturated running sum.
module kalman_mac
  import kalman_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic signed [N-1:0] res_o
);
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    prod  = a_i * b_i;
    acc_d = (clr_i ? '0 : acc_q) + ACC_W'(prod);
    res_o = sat(acc_d >>> Q);
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end
endmodule

// File: rtl/kalman_cov_predict.sv
// kalman_cov_predict: Pp = F*P*F^T + diag(Qn) on one time-shared MAC.
// KALMAN_COV_SYMMETRIZE_EN: compute only the upper triangle in the second pass and mirror it.
module kalman_cov_predict
  import kalman_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [16*N-1:0] F,
  input  logic [16*N-1:0] F_transpose,
  input  logic [16*N-1:0] P,
  input  logic [4*N-1:0]  Qn,
  output logic [16*N-1:0] Pp,
  output logic            busy,
  output logic            done
);
`ifdef KALMAN_COV_SYMMETRIZE_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [16*N-1:0]   f_q, ft_q, p_q, t_q, sh_q, sh_d, pp_q;
  logic [4*N-1:0]    qn_q;
  logic signed [N-1:0] a_op, b_op, mac_res, pp_val;
  logic              active, pass2, last_k, row_end, last_elem;

  kalman_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .en_i  (active),
    .clr_i (k_q == 2'd0),
    .a_i   (a_op),
    .b_i   (b_op),
    .res_o (mac_res)
  );

  always_comb begin
    active    = state_q == PASS1 || state_q == PASS2;
    pass2     = state_q == PASS2;
    last_k    = k_q == 2'd3;
    row_end   = j_q == 2'd3;
    last_elem = last_k && row_end && i_q == 2'd3;
    a_op      = pass2 ? t_q[idx(i_q, k_q)*N +: N] : f_q[idx(i_q, k_q)*N +: N];
    b_op      = pass2 ? ft_q[idx(k_q, j_q)*N +: N] : p_q[idx(k_q, j_q)*N +: N];
    pp_val    = i_q == j_q ? sat(ACC_W'(mac_res) + ACC_W'(signed'(qn_q[i_q*N +: N]))) : mac_res;
    k_d       = active ? k_q + 2'd1 : 2'd0;
    j_d       = !active ? 2'd0 : !last_k ? j_q : !row_end ? j_q + 2'd1 : (SYM && pass2) ? i_q + 2'd1 : 2'd0;
    i_d       = !active ? 2'd0 : (last_k && row_end) ? i_q + 2'd1 : i_q;
    state_d   = state_q == IDLE ? (start ? PASS1 : IDLE)
              : state_q == DONE ? IDLE
              : !last_elem ? state_q
              : pass2 ? DONE : PASS2;
    sh_d      = sh_q;
    if (pass2 && last_k) begin
      sh_d[idx(i_q, j_q)*N +: N] = pp_val;
      if (SYM) sh_d[idx(j_q, i_q)*N +: N] = pp_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      {i_q, j_q, k_q} <= '0;
      {f_q, ft_q, p_q, qn_q} <= '0;
      {t_q, sh_q, pp_q} <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      if (state_q == IDLE && start) begin
        f_q  <= F;
        ft_q <= F_transpose;
        p_q  <= P;
        qn_q <= Qn;
      end
      if (state_q == PASS1 && last_k) t_q[idx(i_q, j_q)*N +: N] <= mac_res;
      if (pass2 && last_elem) pp_q <= sh_d;
    end
  end

  assign Pp   = pp_q;
  assign busy = active;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_kalman_cov_predict.sv
// tb_kalman_cov_predict: directed vectors with hand-computed covariance results.
module tb_kalman_cov_predict;
  localparam int N = 32;
  localparam logic [N-1:0] ONE = 32'd262144;
`ifdef KALMAN_COV_SYMMETRIZE_EN
  localparam int LAT = 104;
  localparam bit SYM = 1'b1;
`else
  localparam int LAT = 128;
  localparam bit SYM = 1'b0;
`endif

  logic            clk = 0, reset = 1, start = 0, busy, done;
  logic [16*N-1:0] F = '0, F_transpose = '0, P = '0, Pp, expm;
  logic [4*N-1:0]  Qn = '0;
  int              checks = 0, passes = 0;

  kalman_cov_predict dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .F           (F),
    .F_transpose (F_transpose),
    .P           (P),
    .Qn          (Qn),
    .Pp          (Pp),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic int o(input int r, input int c);
    return (4 * r + c) * N;
  endfunction

  function automatic logic [16*N-1:0] diag(input logic [N-1:0] a, b, c, d);
    logic [16*N-1:0] m;
    m = '0;
    m[o(0, 0) +: N] = a;
    m[o(1, 1) +: N] = b;
    m[o(2, 2) +: N] = c;
    m[o(3, 3) +: N] = d;
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_mat(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_Pp%0d%0d", tag, r, c), Pp[o(r, c) +: N], expm[o(r, c) +: N]);
  endtask

  task automatic run_op(input string tag);
    int n, nbusy;
    start = 1;
    tick;
    start = 0;
    F = '1; F_transpose = '1; P = '1; Qn = '1;
    n = 0;
    nbusy = 0;
    while (!done && n < 300) begin
      nbusy += busy ? 1 : 0;
      tick;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(LAT));
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk_mat(tag);
    tick;
  endtask

  initial begin
    int dones;
    tick; tick;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    expm = '0;
    chk_mat("reset");
    reset = 0;
    tick;

    F = diag(ONE, ONE, ONE, ONE); F_transpose = F; P = F; Qn = '0;
    expm = diag(ONE, ONE, ONE, ONE);
    run_op("identity");

    F = diag(ONE, ONE, ONE, ONE); F_transpose = F;
    P = diag(32'd524288, 32'd524288, 32'd524288, 32'd524288);
    Qn = {4{32'd131072}};
    expm = diag(32'd655360, 32'd655360, 32'd655360, 32'd655360);
    run_op("noise");

    F = diag(ONE, ONE, ONE, ONE); F[o(3, 2) +: N] = ONE;
    F_transpose = diag(ONE, ONE, ONE, ONE); F_transpose[o(2, 3) +: N] = ONE;
    P = diag(ONE, ONE, ONE, ONE); Qn = '0;
    expm = diag(ONE, ONE, ONE, 32'd524288);
    expm[o(2, 3) +: N] = ONE;
    expm[o(3, 2) +: N] = ONE;
    run_op("coupling");

    F = diag(32'd524288, 32'd524288, 32'd524288, 32'd524288); F_transpose = F;
    P = diag(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF); Qn = '0;
    expm = P;
    run_op("sat_pos");

    F = diag(32'd524288, 32'd524288, 32'd524288, 32'd524288); F_transpose = F;
    P = diag(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000); Qn = '0;
    expm = P;
    run_op("sat_neg");

    F = diag(32'd131072, 32'd131072, 32'd131072, 32'd131072); F_transpose = F;
    P = diag(32'd3, -32'sd3, 32'd3, -32'sd3); Qn = '0;
    expm = diag(32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF);
    run_op("truncate");

    F = diag(ONE, ONE, ONE, ONE); F_transpose = F; P = F; Qn = '0;
    start = 1;
    dones = 0;
    for (int n = 0; n < 300; n++) begin
      tick;
      if (done) begin
        dones++;
        start = 0;
      end
    end
    start = 0;
    chk("held_start_dones", 32'(dones), 32'd1);

    F = diag(ONE, ONE, ONE, ONE); F_transpose = F;
    P = diag(32'd524288, 32'd524288, 32'd524288, 32'd524288); Qn = '0;
    start = 1;
    tick;
    start = 0;
    repeat (49) tick;
    reset = 1;
    tick;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    expm = '0;
    chk_mat("midreset");
    reset = 0;
    tick;
    F = diag(ONE, ONE, ONE, ONE); F_transpose = F; P = F; Qn = '0;
    expm = diag(ONE, ONE, ONE, ONE);
    run_op("after_reset");

    F = diag(ONE, ONE, ONE, ONE); F_transpose = F;
    P = diag(ONE, ONE, ONE, ONE); P[o(0, 1) +: N] = ONE; Qn = '0;
    expm = diag(ONE, ONE, ONE, ONE);
    expm[o(0, 1) +: N] = ONE;
    expm[o(1, 0) +: N] = SYM ? ONE : 32'd0;
    run_op("upper");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
